tqvp_dlmiles_i2c_seq: RTL

TQVP_DLMILES_I2C_SEQ -- requirements
Module: tqvp_dlmiles_i2c_seq

---
 rtl/tqvp_dlmiles_i2c_seq_pkg.sv | 29 ++
 rtl/tqvp_dlmiles_i2c_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tqvp_dlmiles_i2c_seq_pkg.sv
// tqvp_dlmiles_i2c_seq_pkg: shared txd word layout, result codes and sequencer state encoding
package tqvp_dlmiles_i2c_seq_pkg;
  localparam int TXD_START = 11;
  localparam int TXD_STOP  = 10;
  localparam int TXD_RD    = 9;
  localparam int TXD_NACK  = 8;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_BUS  = 2'b10;
  localparam logic [1:0] ERR_CMD  = 2'b11;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_AW    = 4'd1;
  localparam logic [3:0] S_REG   = 4'd2;
  localparam logic [3:0] S_WD    = 4'd3;
  localparam logic [3:0] S_AR    = 4'd4;
  localparam logic [3:0] S_RD    = 4'd5;
  localparam logic [3:0] S_DRAIN = 4'd6;
  localparam logic [3:0] S_STOPX = 4'd7;
  localparam logic [3:0] S_FIN   = 4'd8;
  function automatic logic [11:0] txd_word(input logic s, input logic p, input logic r,
                                           input logic n, input logic [7:0] b);
    txd_word = 12'h000;
    txd_word[TXD_START] = s;
    txd_word[TXD_STOP] = p;
    txd_word[TXD_RD] = r;
    txd_word[TXD_NACK] = n;
    txd_word[7:0] = b;
  endfunction
endpackage

// File: rtl/tqvp_dlmiles_i2c_seq.sv
// tqvp_dlmiles_i2c_seq: turns one register-addressed I2C read/write command into a stream of bus FIFO words
module tqvp_dlmiles_i2c_seq
  import tqvp_dlmiles_i2c_seq_pkg::*;
#(
  parameter int MAXLEN = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_reg,
  input  logic [3:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [11:0] txd_data,
  output logic        txd_valid,
  input  logic        txd_ready,
  input  logic        ack_valid,
  input  logic        ack_nack,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        bus_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);
  logic [3:0] state_q, state_d, len_q, cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [6:0] addr_q;
  logic [7:0] reg_q;
  logic [4:0] pend_q, pend_d;
  logic [1:0] err_q, err_d;
  logic       rw_q, stop_q, stop_d;
  logic       accept, fire, bad, last, err_on, push_np;
  assign cmd_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  assign err       = err_q;
  assign accept    = cmd_valid & cmd_ready;
  assign bad       = (cmd_rw && cmd_len == 4'd0) || ({1'b0, cmd_len} > 5'(MAXLEN));
  assign last      = cnt_q == 4'd1;
  always_comb
    txd_data = state_q == S_AW    ? txd_word(1'b1, 1'b0, 1'b0, 1'b0, {addr_q, 1'b0}) :
               state_q == S_REG   ? txd_word(1'b0, !rw_q && len_q == 4'd0, 1'b0, 1'b0, reg_q) :
               state_q == S_WD    ? txd_word(1'b0, last, 1'b0, 1'b0, wr_data) :
               state_q == S_AR    ? txd_word(1'b1, 1'b0, 1'b0, 1'b0, {addr_q, 1'b1}) :
               state_q == S_RD    ? txd_word(1'b0, last, 1'b1, last, 8'h00) :
               state_q == S_STOPX ? txd_word(1'b0, 1'b1, 1'b0, 1'b0, 8'h00) : 12'h000;
  assign txd_valid = state_q == S_AW || state_q == S_REG || state_q == S_AR ||
                     state_q == S_RD || state_q == S_STOPX || (state_q == S_WD && wr_valid);
  assign wr_ready  = state_q == S_WD && txd_ready;
  assign fire      = txd_valid && txd_ready;
  assign push_np   = fire && !txd_data[TXD_RD];
  assign rd_valid  = rx_valid && rcnt_q != 4'd0;
  assign rd_data   = rx_data;
  assign err_on    = state_q != S_IDLE && state_q != S_FIN && state_q != S_STOPX &&
                     (bus_err || (ack_valid && ack_nack) || abort);
  // An ack arriving with a push leaves the outstanding count unchanged
  assign pend_d = accept ? 5'd0 :
                  push_np && !ack_valid ? pend_q + 5'd1 :
                  ack_valid && !push_np && pend_q != 5'd0 ? pend_q - 5'd1 : pend_q;
  assign rcnt_d = accept ? (cmd_rw ? cmd_len : 4'd0) : rd_valid ? rcnt_q - 4'd1 : rcnt_q;
  assign stop_d = !accept && (stop_q || (fire && txd_data[TXD_STOP]));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      S_IDLE:  if (accept) begin
                 err_d = bad ? ERR_CMD : ERR_OK;
                 state_d = bad ? S_FIN : S_AW;
               end
      S_AW:    if (fire) state_d = S_REG;
      S_REG:   if (fire) begin
                 state_d = rw_q ? S_AR : len_q == 4'd0 ? S_DRAIN : S_WD;
                 cnt_d = len_q;
               end
      S_WD, S_RD: if (fire) begin
                 cnt_d = cnt_q - 4'd1;
                 state_d = last ? S_DRAIN : state_q;
               end
      S_AR:    if (fire) state_d = S_RD;
      S_DRAIN: if (pend_q == 5'd0 && rcnt_q == 4'd0) state_d = S_FIN;
      S_STOPX: if (fire) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
    // A word already carrying STOP has closed the bus, so no extra STOP is needed
    if (err_on) begin
      err_d = bus_err ? ERR_BUS : (ack_valid && ack_nack) ? ERR_NACK : ERR_CMD;
      state_d = stop_d ? S_FIN : S_STOPX;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rcnt_q <= '0;
      pend_q <= '0;
      err_q <= ERR_OK;
      stop_q <= 1'b0;
      addr_q <= '0;
      rw_q <= 1'b0;
      reg_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcnt_q <= rcnt_d;
      pend_q <= pend_d;
      err_q <= err_d;
      stop_q <= stop_d;
      if (accept) begin
        addr_q <= cmd_addr;
        rw_q <= cmd_rw;
        reg_q <= cmd_reg;
        len_q <= cmd_len;
      end
    end
endmodule
